// File: rtl/isl51002_fe_pkg.sv
// Shared types and constants for the ISL51002 sync-lock controller.
package isl51002_fe_pkg;

    typedef enum logic [1:0] {
        ST_UNLOCKED  = 2'd0,
        ST_CANDIDATE = 2'd1,
        ST_LOCKED    = 2'd2,
        ST_HOLD      = 2'd3
    } lock_state_t;

    localparam int CNT_W  = 4;
    localparam int TMO_W  = 22;
    localparam int VT_W   = 11;
    localparam int PCNT_W = 20;
    localparam int HV_W   = 32;

    // Word positions of hv_in_config, hv_in_config2, hv_in_config3 in the packed slot.
    localparam int HV1_LSB = 0;
    localparam int HV2_LSB = HV_W;
    localparam int HV3_LSB = 2 * HV_W;
    localparam int CFG_W   = 3 * HV_W;

    function automatic logic pcnt_in_tol(input logic [PCNT_W-1:0] meas,
                                         input logic [PCNT_W-1:0] rv,
                                         input int unsigned       tol);
        logic signed [PCNT_W:0] diff;
        logic        [PCNT_W:0] mag;
        diff = $signed({1'b0, meas}) - $signed({1'b0, rv});
        mag  = diff[PCNT_W] ? $unsigned(-diff) : $unsigned(diff);
        return 32'(mag) <= tol;
    endfunction

endpackage

// File: rtl/isl51002_sync_lock_ctrl_if.sv
// CPU-side configuration and interrupt bus of the ISL51002 sync-lock controller.
interface isl51002_sync_lock_ctrl_if;
    import isl51002_fe_pkg::*;

    logic            cfg_wr;
    logic [HV_W-1:0] cfg_hv;
    logic [HV_W-1:0] cfg_hv2;
    logic [HV_W-1:0] cfg_hv3;
    logic            irq_clr;
    logic            cfg_pending;
    logic            cfg_applied;
    logic            mode_irq;

    modport master (
        output cfg_wr, cfg_hv, cfg_hv2, cfg_hv3, irq_clr,
        input  cfg_pending, cfg_applied, mode_irq
    );

    modport slave (
        input  cfg_wr, cfg_hv, cfg_hv2, cfg_hv3, irq_clr,
        output cfg_pending, cfg_applied, mode_irq
    );

endinterface

// File: rtl/isl51002_sync_lock_ctrl_cfg_shadow.sv
// Pending/apply slot for the hv_in_config words. A write that lands on an apply
// cycle becomes the new pending data while the previous slot contents are applied.
module sync_lock_cfg_shadow
    import isl51002_fe_pkg::*;
(
    input  logic             PCLK_i,
    input  logic             reset_n,
    input  logic             wr,
    input  logic [CFG_W-1:0] wr_data,
    input  logic             apply,
    output logic             pending,
    output logic             applied,
    output logic [CFG_W-1:0] cfg_out
);

    logic [CFG_W-1:0] slot;

    always_ff @(posedge PCLK_i) begin
        if (!reset_n) begin
            slot    <= '0;
            pending <= 1'b0;
            applied <= 1'b0;
            cfg_out <= '0;
        end else begin
            applied <= apply;
            if (apply)
                cfg_out <= slot;
            if (wr) begin
                slot    <= wr_data;
                pending <= 1'b1;
            end else if (apply) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/isl51002_sync_lock_ctrl.sv
// Sync lock/loss sequencer and frame-aligned config apply for the ISL51002 frontend.
// Optional sync-loss watchdog enabled by defining SYNC_LOSS_TIMEOUT_EN.
//
//   state        | meaning
//   UNLOCKED     | no reference; next valid frame loads one
//   CANDIDATE    | reference loaded, counting consecutive matching frames
//   LOCKED       | locked, every frame matches the reference
//   HOLD         | locked, counting consecutive mismatching frames
module isl51002_sync_lock_ctrl
    import isl51002_fe_pkg::*;
#(
`ifdef SYNC_LOSS_TIMEOUT_EN
    parameter int unsigned TIMEOUT_CYCLES = 2097152,
`endif
    parameter int unsigned LOCK_FRAMES    = 4,
    parameter int unsigned UNLOCK_FRAMES  = 2,
    parameter int unsigned PCNT_TOL       = 16
) (
    input  logic                     PCLK_i,
    input  logic                     reset_n,
    input  logic                     frame_change_i,
    input  logic [VT_W-1:0]          vtotal_i,
    input  logic [PCNT_W-1:0]        pcnt_frame_i,
    input  logic                     interlace_flag_i,
    isl51002_sync_lock_ctrl_if.slave cpu,
    output logic [HV_W-1:0]          hv_in_config_o,
    output logic [HV_W-1:0]          hv_in_config2_o,
    output logic [HV_W-1:0]          hv_in_config3_o,
    output logic                     lock_o,
    output logic [VT_W-1:0]          ref_vtotal_o,
    output logic                     ref_interlace_o
);

    localparam logic [CNT_W-1:0] LOCK_N   = CNT_W'(LOCK_FRAMES);
    localparam logic [CNT_W-1:0] UNLOCK_N = CNT_W'(UNLOCK_FRAMES);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    lock_state_t       state;
    logic              frame_change_q;
    logic [PCNT_W-1:0] ref_pcnt;
    logic [CNT_W-1:0]  match_cnt;
    logic [CNT_W-1:0]  miss_cnt;
    logic [CNT_W-1:0]  match_inc;
    logic [CNT_W-1:0]  miss_inc;
    logic              mode_irq_q;
    logic              fe;
    logic              matched;
    logic              locked_st;
    logic              apply;
    logic              tmo_hit;
    logic [CFG_W-1:0]  cfg_out;

    assign fe        = frame_change_i & ~frame_change_q;
    assign matched   = (vtotal_i == ref_vtotal_o) && (interlace_flag_i == ref_interlace_o) &&
                       pcnt_in_tol(pcnt_frame_i, ref_pcnt, PCNT_TOL);
    assign locked_st = (state == ST_LOCKED) || (state == ST_HOLD);
    assign match_inc = (match_cnt == CNT_MAX) ? match_cnt : match_cnt + CNT_W'(1);
    assign miss_inc  = (miss_cnt == CNT_MAX) ? miss_cnt : miss_cnt + CNT_W'(1);

    // Locked: wait for the frame boundary. Otherwise apply as soon as pending.
    assign apply = cpu.cfg_pending & (locked_st ? fe : 1'b1);

`ifdef SYNC_LOSS_TIMEOUT_EN
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge PCLK_i) begin
        if (!reset_n)
            tmo_cnt <= '0;
        else if (fe)
            tmo_cnt <= '0;
        else if (tmo_cnt != TMO_LAST)
            tmo_cnt <= tmo_cnt + TMO_W'(1);
    end

    assign tmo_hit = (tmo_cnt == TMO_LAST) & ~fe;
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge PCLK_i) begin
        if (!reset_n) begin
            state           <= ST_UNLOCKED;
            frame_change_q  <= 1'b0;
            ref_vtotal_o    <= '0;
            ref_interlace_o <= 1'b0;
            ref_pcnt        <= '0;
            match_cnt       <= '0;
            miss_cnt        <= '0;
            lock_o          <= 1'b0;
            mode_irq_q      <= 1'b0;
        end else begin
            frame_change_q <= frame_change_i;
            if (cpu.irq_clr)
                mode_irq_q <= 1'b0;

            // A new config or a vanished sync restarts acquisition from scratch.
            if ((apply || tmo_hit) && state != ST_UNLOCKED) begin
                state     <= ST_UNLOCKED;
                lock_o    <= 1'b0;
                match_cnt <= '0;
                miss_cnt  <= '0;
                if (locked_st)
                    mode_irq_q <= 1'b1;
            end else if (fe) begin
                case (state)
                    ST_UNLOCKED: begin
                        if (vtotal_i != '0) begin
                            ref_vtotal_o    <= vtotal_i;
                            ref_interlace_o <= interlace_flag_i;
                            ref_pcnt        <= pcnt_frame_i;
                            match_cnt       <= CNT_W'(1);
                            if (LOCK_N <= CNT_W'(1)) begin
                                state      <= ST_LOCKED;
                                lock_o     <= 1'b1;
                                mode_irq_q <= 1'b1;
                            end else begin
                                state <= ST_CANDIDATE;
                            end
                        end
                    end
                    ST_CANDIDATE: begin
                        if (matched) begin
                            match_cnt <= match_inc;
                            if (match_inc >= LOCK_N) begin
                                state      <= ST_LOCKED;
                                miss_cnt   <= '0;
                                lock_o     <= 1'b1;
                                mode_irq_q <= 1'b1;
                            end
                        end else begin
                            ref_vtotal_o    <= vtotal_i;
                            ref_interlace_o <= interlace_flag_i;
                            ref_pcnt        <= pcnt_frame_i;
                            match_cnt       <= CNT_W'(1);
                        end
                    end
                    ST_LOCKED: begin
                        if (matched) begin
                            miss_cnt <= '0;
                        end else if (UNLOCK_N <= CNT_W'(1)) begin
                            state      <= ST_UNLOCKED;
                            match_cnt  <= '0;
                            miss_cnt   <= '0;
                            lock_o     <= 1'b0;
                            mode_irq_q <= 1'b1;
                        end else begin
                            state    <= ST_HOLD;
                            miss_cnt <= CNT_W'(1);
                        end
                    end
                    ST_HOLD: begin
                        if (matched) begin
                            state    <= ST_LOCKED;
                            miss_cnt <= '0;
                        end else if (miss_inc >= UNLOCK_N) begin
                            state      <= ST_UNLOCKED;
                            match_cnt  <= '0;
                            miss_cnt   <= '0;
                            lock_o     <= 1'b0;
                            mode_irq_q <= 1'b1;
                        end else begin
                            miss_cnt <= miss_inc;
                        end
                    end
                    default: state <= ST_UNLOCKED;
                endcase
            end
        end
    end

    assign cpu.mode_irq = mode_irq_q;

    sync_lock_cfg_shadow u_shadow (
        .PCLK_i  (PCLK_i),
        .reset_n (reset_n),
        .wr      (cpu.cfg_wr),
        .wr_data ({cpu.cfg_hv3, cpu.cfg_hv2, cpu.cfg_hv}),
        .apply   (apply),
        .pending (cpu.cfg_pending),
        .applied (cpu.cfg_applied),
        .cfg_out (cfg_out)
    );

    assign hv_in_config_o  = cfg_out[HV1_LSB +: HV_W];
    assign hv_in_config2_o = cfg_out[HV2_LSB +: HV_W];
    assign hv_in_config3_o = cfg_out[HV3_LSB +: HV_W];

endmodule

// File: doc/isl51002_sync_lock_ctrl.md
Name: isl51002_sync_lock_ctrl

Overview:
Sequences the ISL51002 frontend datapath.
- Watches the frontend's frame measurements (vtotal, pcnt_frame, interlace_flag, frame_change) and decides sync lock or loss.
- Raises a mode-change interrupt to the CPU.
- Applies CPU-written hv_in_config words to the frontend only on frame boundaries, so timing regeneration never sees a torn configuration.
- Sits between the CPU register bank and the isl51002_frontend instance.

Parameters:
LOCK_FRAMES, 4, consecutive matching frames required to enter LOCKED (range 1-15)
UNLOCK_FRAMES, 2, consecutive mismatching frames required to drop lock (range 1-15)
PCNT_TOL, 16, allowed absolute pcnt_frame deviation from the reference, in CLK_MEAS counts
TIMEOUT_CYCLES, 2097152, PCLK_i cycles without frame_change_i before sync is declared lost

Ports:
PCLK_i  in  1  pixel clock; the only clock
reset_n  in  1  synchronous active-low reset
frame_change_i  in  1  frontend frame_change output; a frame boundary is its rising edge
vtotal_i  in  11  frontend measured line count, already in the PCLK_i domain
pcnt_frame_i  in  20  frontend measured frame length, already in the PCLK_i domain
interlace_flag_i  in  1  frontend interlace flag
cfg_wr_i  in  1  one-cycle strobe: capture cfg_*_i into the pending slot
cfg_hv_i  in  32  new hv_in_config
cfg_hv2_i  in  32  new hv_in_config2
cfg_hv3_i  in  32  new hv_in_config3
irq_clr_i  in  1  one-cycle strobe that clears mode_irq_o
hv_in_config_o  out  32  applied config to the frontend
hv_in_config2_o  out  32  applied config to the frontend
hv_in_config3_o  out  32  applied config to the frontend
cfg_pending_o  out  1  a pending config has not yet been applied
cfg_applied_o  out  1  one-cycle pulse when the pending config is applied
lock_o  out  1  high in LOCKED and HOLD
mode_irq_o  out  1  sticky interrupt
ref_vtotal_o  out  11  reference vtotal captured at lock
ref_interlace_o  out  1  reference interlace flag captured at lock

Behaviour:
- Reset (reset_n low at a PCLK_i edge): all outputs 0, all counters 0, state UNLOCKED, pending slot empty.
- Frame event: fe = frame_change_i & ~frame_change_q. Measurements are sampled on the fe cycle.
- Match condition: vtotal_i == ref_vtotal, interlace_flag_i == ref_interlace, and |pcnt_frame_i - ref_pcnt| <= PCNT_TOL.
  - Compute the deviation on a 21-bit signed difference.
  - Update ref_* on the cycle after the fe that loads them.
- UNLOCKED:
  - On fe, load ref_* from the inputs, set match_cnt = 1, go to CANDIDATE.
  - Ignore any fe where vtotal_i == 0.
- CANDIDATE, on fe:
  - If matched, match_cnt++. When match_cnt reaches LOCK_FRAMES, go to LOCKED, set lock_o and mode_irq_o.
  - If not matched, reload ref_* and set match_cnt = 1 (stay in CANDIDATE).
- LOCKED, on fe:
  - Matched: miss_cnt = 0.
  - Mismatch: miss_cnt = 1, go to HOLD.
- HOLD, on fe:
  - Matched: miss_cnt = 0, back to LOCKED.
  - Mismatch: miss_cnt++. When it reaches UNLOCK_FRAMES, go to UNLOCKED, clear lock_o, set mode_irq_o.
  - With UNLOCK_FRAMES = 1, LOCKED goes directly to UNLOCKED on the first mismatch.
- lock_o is registered: it changes on the cycle after the state transition.
- mode_irq_o:
  - Set on every lock or unlock transition; cleared by irq_clr_i.
  - A set and a clear in the same cycle leave it set (set wins).
- Config shadow:
  - cfg_wr_i captures cfg_*_i into the pending slot and sets cfg_pending_o.
  - A second write before apply overwrites the slot (last write wins).
- Config apply:
  - In LOCKED or HOLD, apply on the next fe.
  - In UNLOCKED or CANDIDATE, apply on the cycle after capture.
  - Apply means: copy pending to hv_in_config*_o, clear cfg_pending_o, pulse cfg_applied_o for 1 cycle.
  - If cfg_wr_i coincides with an apply fe, apply the old pending data; the new data becomes pending (cfg_pending_o stays 1).
  - Any apply while in LOCKED, HOLD or CANDIDATE forces UNLOCKED (no irq if already unlocked). The new config changes the regenerated timing, so lock is re-acquired from scratch.
- Counters saturate; match_cnt and miss_cnt are 4 bits.

Optional Feature:
SYNC_LOSS_TIMEOUT_EN.
- Defined:
  - A 22-bit cycle counter clears on fe and increments otherwise.
  - When it reaches TIMEOUT_CYCLES-1 in any state except UNLOCKED, go to UNLOCKED and clear lock_o. If the block was locked, also set mode_irq_o.
  - The counter then saturates until the next fe.
- Undefined: no counter. Loss is detected only via frame mismatches, so a vanished sync holds LOCKED indefinitely.

Decomposition:
- Package isl51002_fe_pkg:
  - state encoding constants (UNLOCKED, CANDIDATE, LOCKED, HOLD);
  - field-position constants for the hv_in_config words;
  - the counter-width constant.
- One natural sub-module, sync_lock_cfg_shadow: the pending/apply register slot with the write/apply collision rule.
- The FSM stays in the top module.

Test Plan:
- Lock acquisition: after reset, 5 frames of vtotal=525, pcnt=450450, interlace=0 -> lock_o rises 1 cycle after the 4th fe; mode_irq_o=1; ref_vtotal_o=525.
- Tolerance: while locked, pcnt=450466 (+16) stays LOCKED; pcnt=450467 (+17) on 2 consecutive frames -> lock_o=0 and irq set.
- Hold recovery: a single mismatch frame (vtotal=526) then matching frames -> lock_o never drops; mode_irq_o unchanged after irq_clr_i.
- Config apply while locked: cfg_wr_i with cfg_hv_i=32'h2C2D0360 mid-frame -> cfg_pending_o=1 until the next fe, then outputs update with a 1-cycle cfg_applied_o pulse and the state goes UNLOCKED. Also assert cfg_wr_i on the same cycle as fe -> old data applied, new data stays pending.
- Irq race: irq_clr_i on the same cycle as the lock transition -> mode_irq_o=1.
- Timeout (macro on, TIMEOUT_CYCLES=1000): lock, then stop frame_change_i -> lock_o falls 1000 cycles after the last fe; irq set. With the macro off, lock_o stays 1.
